// File: rtl/descriptor_extract_gen_if.sv
// Frame-path bundle for descriptor_extract_gen: input byte stream, forwarded stream and descriptor strobe.
// The DUT connects the slave modport and the frame source connects the master modport.
interface descriptor_extract_gen_if #(
    parameter int HDR_BYTES = 6
);
    localparam int DW_DESC = 8 * HDR_BYTES + 24;

    logic [8:0]         iv_data;
    logic               i_data_wr;
    logic [8:0]         ov_data;
    logic               o_data_wr;
    logic [DW_DESC-1:0] ov_descriptor;
    logic               o_descriptor_valid;

    modport master (
        output iv_data, i_data_wr,
        input  ov_data, o_data_wr, ov_descriptor, o_descriptor_valid
    );

    modport slave (
        input  iv_data, i_data_wr,
        output ov_data, o_data_wr, ov_descriptor, o_descriptor_valid
    );
endinterface

// File: rtl/descriptor_extract_gen.sv
// Per-port descriptor extractor: head-byte admission, 1-cycle forwarding with PTP timestamp insertion,
// header descriptor generation. Define DISCARD_STAT_EN to build the discard/error statistics counters.
module descriptor_extract_gen #(
    parameter logic [3:0] INPORT    = 4'b0000,
    parameter int         HDR_BYTES = 6,
    parameter int         TS_W      = 19,
    parameter int         TS_OFFSET = 3,
    parameter int         CNT_W     = 9
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    descriptor_extract_gen_if.slave frm,
    input  logic                 i_standardpkt_tsnpkt_flag,
    input  logic                 port_type,
    input  logic [TS_W-1:0]      iv_rec_ts,
    input  logic [CNT_W-1:0]     iv_free_bufid_cnt,
    input  logic [CNT_W-1:0]     iv_be_threshold,
    input  logic [CNT_W-1:0]     iv_rc_threshold,
    input  logic [CNT_W-1:0]     iv_map_threshold,
    output logic                 o_pkt_discard_pulse,
    output logic                 o_pkt_error_pulse,
    output logic [15:0]          ov_discard_cnt,
    output logic [15:0]          ov_error_cnt,
    output logic [1:0]           ov_state
);
    localparam int         KEY_W    = 8 * HDR_BYTES;
    localparam int         TS_BYTES = (TS_W + 7) / 8;
    localparam int         TS_REM   = TS_W % 8;
    localparam logic [7:0] KEEP_MASK = (TS_REM == 0) ? 8'h00 : 8'(8'hFF << TS_REM);
    localparam logic [2:0] LAST_IDX = 3'(HDR_BYTES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2, DISC = 2'd3} state_t;

    state_t              state_q;
    logic [2:0]          idx_q;
    logic [TS_W-1:0]     ts_q;
    logic [2:0]          class_q;
    logic                mapped_q;
    logic                std_q;
    logic                lookup_q;
    logic [KEY_W-1:0]    key_q;

    logic                is_head;
    logic                head_mapped;
    logic [2:0]          head_class;
    logic                head_lookup;
    logic                head_drop;
    logic                ptp_now;
    logic [2:0]          pos;
    logic [8*TS_BYTES-1:0] ts_pad;
    logic [7:0]          out_byte;
    logic [KEY_W-1:0]    key_next;

    assign is_head     = frm.i_data_wr && frm.iv_data[8];
    assign head_mapped = !i_standardpkt_tsnpkt_flag && !port_type;
    assign head_class  = head_mapped ? frm.iv_data[7:5] : 3'd6;
    assign head_lookup = i_standardpkt_tsnpkt_flag || !port_type;
    assign ov_state    = state_q;

    // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        head_drop = (iv_free_bufid_cnt == '0);
        if (!head_mapped) begin
            head_drop = head_drop || (iv_free_bufid_cnt <= iv_map_threshold);
        end else if (head_class == 3'd3) begin
            head_drop = head_drop || (iv_free_bufid_cnt <= iv_rc_threshold);
        end else if (head_class == 3'd6) begin
            head_drop = head_drop || (iv_free_bufid_cnt <= iv_rc_threshold)
                                  || (iv_free_bufid_cnt <= iv_be_threshold);
        end
    end

    // Timestamp insertion: in IDLE the head byte (position 0) uses the live timestamp.
    always_comb begin
        ts_pad            = '0;
        ts_pad[TS_W-1:0]  = (state_q == IDLE) ? iv_rec_ts : ts_q;
        pos               = (state_q == IDLE) ? 3'd0 : idx_q;
        ptp_now           = (state_q == IDLE) ? (head_mapped && head_class == 3'd4)
                                              : (mapped_q && class_q == 3'd4);
        out_byte          = frm.iv_data[7:0];
        if (ptp_now) begin
            for (int m = 0; m < TS_BYTES; m++) begin
                if (pos == 3'(TS_OFFSET + m)) begin
                    out_byte = ((m == 0) ? (frm.iv_data[7:0] & KEEP_MASK) : 8'h00)
                             | ts_pad[8*(TS_BYTES-1-m) +: 8];
                end
            end
        end
        key_next = key_q;
        for (int k = 1; k < HDR_BYTES; k++) begin
            if (idx_q == 3'(k)) key_next[8*(HDR_BYTES-k)-1 -: 8] = frm.iv_data[7:0];
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q                <= IDLE;
            idx_q                  <= '0;
            ts_q                   <= '0;
            class_q                <= '0;
            mapped_q               <= 1'b0;
            std_q                  <= 1'b0;
            lookup_q               <= 1'b0;
            key_q                  <= '0;
            frm.ov_data            <= '0;
            frm.o_data_wr          <= 1'b0;
            frm.ov_descriptor      <= '0;
            frm.o_descriptor_valid <= 1'b0;
            o_pkt_discard_pulse    <= 1'b0;
            o_pkt_error_pulse      <= 1'b0;
        end else begin
            frm.ov_data            <= {frm.iv_data[8], out_byte};
            frm.o_data_wr          <= frm.i_data_wr;
            frm.o_descriptor_valid <= 1'b0;
            o_pkt_discard_pulse    <= 1'b0;
            o_pkt_error_pulse      <= 1'b0;
            case (state_q)
                IDLE: begin
                    frm.o_data_wr <= 1'b0;
                    if (is_head) begin
                        ts_q     <= iv_rec_ts;
                        class_q  <= head_class;
                        mapped_q <= head_mapped;
                        std_q    <= i_standardpkt_tsnpkt_flag;
                        lookup_q <= head_lookup;
                        if (head_drop) begin
                            o_pkt_discard_pulse <= 1'b1;
                            state_q             <= DISC;
                        end else begin
                            frm.o_data_wr <= 1'b1;
                            key_q         <= {frm.iv_data[7:0], {(KEY_W-8){1'b0}}};
                            idx_q         <= 3'd1;
                            state_q       <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (!frm.i_data_wr) begin
                        o_pkt_error_pulse <= 1'b1;
                        frm.ov_descriptor <= '0;
                        state_q           <= IDLE;
                    end else begin
                        key_q <= key_next;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == LAST_IDX) begin
                            frm.o_descriptor_valid <= 1'b1;
                            frm.ov_descriptor <= {key_next, std_q, INPORT, lookup_q,
                                                  mapped_q ? 9'h000 : 9'h100, 9'h000};
                            state_q <= frm.iv_data[8] ? IDLE : BODY;
                        end else if (frm.iv_data[8]) begin
                            o_pkt_error_pulse <= 1'b1;
                            frm.ov_descriptor <= '0;
                            state_q           <= IDLE;
                        end
                    end
                end
                BODY: begin
                    if (!frm.i_data_wr || frm.iv_data[8]) state_q <= IDLE;
                end
                DISC: begin
                    frm.o_data_wr <= 1'b0;
                    if (is_head) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DISCARD_STAT_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ov_discard_cnt <= '0;
            ov_error_cnt   <= '0;
        end else begin
            if (o_pkt_discard_pulse && ov_discard_cnt != 16'hFFFF) ov_discard_cnt <= ov_discard_cnt + 16'd1;
            if (o_pkt_error_pulse && ov_error_cnt != 16'hFFFF)     ov_error_cnt   <= ov_error_cnt + 16'd1;
        end
    end
`else
    assign ov_discard_cnt = '0;
    assign ov_error_cnt   = '0;
`endif
endmodule

// File: tb/tb_descriptor_extract_gen.sv
// Directed bench for descriptor_extract_gen: expected bytes, descriptors and pulses are queued with their
// due cycle when stimulus is driven and compared by a negedge monitor.
module tb_descriptor_extract_gen;
    localparam int         HDR_BYTES = 6;
    localparam int         TS_W      = 19;
    localparam int         CNT_W     = 9;
    localparam int         DW        = 8 * HDR_BYTES + 24;
    localparam logic [3:0] INPORT    = 4'b0000;
`ifdef DISCARD_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    typedef logic [DW-1:0] word_t;
    typedef struct { int cyc; logic [8:0] data; } exp_byte_t;
    typedef struct { int cyc; logic [DW-1:0] desc; } exp_desc_t;

    logic             clk_sys = 1'b0;
    logic             reset_n = 1'b0;
    logic             std_flag, port_type;
    logic [TS_W-1:0]  rec_ts;
    logic [CNT_W-1:0] free_cnt, be_thr, rc_thr, map_thr;
    logic             discard_pulse, error_pulse;
    logic [15:0]      discard_cnt, error_cnt;
    logic [1:0]       state;

    descriptor_extract_gen_if #(.HDR_BYTES(HDR_BYTES)) frm ();

    descriptor_extract_gen #(
        .INPORT(INPORT), .HDR_BYTES(HDR_BYTES), .TS_W(TS_W), .TS_OFFSET(3), .CNT_W(CNT_W)
    ) dut (
        .clk_sys                   (clk_sys),
        .reset_n                   (reset_n),
        .frm                       (frm),
        .i_standardpkt_tsnpkt_flag (std_flag),
        .port_type                 (port_type),
        .iv_rec_ts                 (rec_ts),
        .iv_free_bufid_cnt         (free_cnt),
        .iv_be_threshold           (be_thr),
        .iv_rc_threshold           (rc_thr),
        .iv_map_threshold          (map_thr),
        .o_pkt_discard_pulse       (discard_pulse),
        .o_pkt_error_pulse         (error_pulse),
        .ov_discard_cnt            (discard_cnt),
        .ov_error_cnt              (error_cnt),
        .ov_state                  (state)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int exp_disc = 0;
    int exp_err = 0;

    exp_byte_t  byte_q[$];
    exp_desc_t  desc_q[$];
    int         disc_q[$];
    int         err_q[$];
    logic [8:0] fin[16];
    logic [8:0] fout[16];

    task automatic check(input string tag, input word_t obs, input word_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    bit due_b, due_d, due_x, due_e;
    always @(negedge clk_sys) begin
        if (reset_n) begin
            due_b = byte_q.size() != 0 && byte_q[0].cyc <= cyc;
            if (frm.o_data_wr || due_b) begin
                check("o_data_wr", word_t'(frm.o_data_wr), word_t'(due_b));
                if (due_b) begin
                    if (frm.o_data_wr) check("ov_data", word_t'(frm.ov_data), word_t'(byte_q[0].data));
                    void'(byte_q.pop_front());
                end
            end
            due_d = desc_q.size() != 0 && desc_q[0].cyc <= cyc;
            if (frm.o_descriptor_valid || due_d) begin
                check("o_descriptor_valid", word_t'(frm.o_descriptor_valid), word_t'(due_d));
                if (due_d) begin
                    if (frm.o_descriptor_valid) check("ov_descriptor", frm.ov_descriptor, desc_q[0].desc);
                    void'(desc_q.pop_front());
                end
            end
            due_x = disc_q.size() != 0 && disc_q[0] <= cyc;
            if (discard_pulse || due_x) begin
                check("o_pkt_discard_pulse", word_t'(discard_pulse), word_t'(due_x));
                if (due_x) void'(disc_q.pop_front());
            end
            due_e = err_q.size() != 0 && err_q[0] <= cyc;
            if (error_pulse || due_e) begin
                check("o_pkt_error_pulse", word_t'(error_pulse), word_t'(due_e));
                if (due_e) void'(err_q.pop_front());
            end
        end
    end

    task automatic drive_byte(input logic [8:0] d, input logic wr);
        @(negedge clk_sys);
        frm.iv_data   = d;
        frm.i_data_wr = wr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_byte(9'h000, 1'b0);
    endtask

    task automatic make_frame(input int len, input logic [7:0] head);
        for (int i = 0; i < len; i++) begin
            fin[i]  = {(i == 0) || (i == len - 1), (i == 0) ? head : 8'(i * 37 + 5)};
            fout[i] = fin[i];
        end
    endtask

    function automatic word_t build_desc(input bit std, input bit lookup, input bit unmapped);
        logic [8*HDR_BYTES-1:0] key;
        key = '0;
        for (int k = 0; k < HDR_BYTES; k++) key[8*(HDR_BYTES-k)-1 -: 8] = fin[k][7:0];
        return {key, std, INPORT, lookup, unmapped ? 9'h100 : 9'h000, 9'h000};
    endfunction

    task automatic run_frame(input int len, input bit admit, input bit err_end,
                             input bit has_desc, input word_t desc);
        for (int i = 0; i < len; i++) begin
            drive_byte(fin[i], 1'b1);
            if (admit) byte_q.push_back('{cyc + 1, fout[i]});
            if (admit && has_desc && i == HDR_BYTES - 1) desc_q.push_back('{cyc + 1, desc});
            if (!admit && i == 0) begin disc_q.push_back(cyc + 1); exp_disc++; end
            if (err_end && i == len - 1) begin err_q.push_back(cyc + 1); exp_err++; end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ov_data"},       word_t'(frm.ov_data), '0);
        check({tag, "_o_data_wr"},     word_t'(frm.o_data_wr), '0);
        check({tag, "_ov_descriptor"}, frm.ov_descriptor, '0);
        check({tag, "_desc_valid"},    word_t'(frm.o_descriptor_valid), '0);
        check({tag, "_discard"},       word_t'(discard_pulse), '0);
        check({tag, "_error"},         word_t'(error_pulse), '0);
        check({tag, "_discard_cnt"},   word_t'(discard_cnt), '0);
        check({tag, "_error_cnt"},     word_t'(error_cnt), '0);
        check({tag, "_state"},         word_t'(state), '0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_discard_cnt"}, word_t'(discard_cnt), word_t'(STAT_EN ? exp_disc : 0));
        check({tag, "_error_cnt"},   word_t'(error_cnt),   word_t'(STAT_EN ? exp_err : 0));
    endtask

    initial begin
        frm.iv_data = '0; frm.i_data_wr = 1'b0;
        std_flag = 1'b0; port_type = 1'b0; rec_ts = '0;
        free_cnt = '0; be_thr = '0; rc_thr = '0; map_thr = '0;
        #12 check_all_zero("reset");
        @(negedge clk_sys); reset_n = 1'b1;

        // Mapped class 3, 10 bytes, comfortably above rc threshold.
        free_cnt = 9'd100; rc_thr = 9'd20; be_thr = 9'd50; map_thr = 9'd50;
        make_frame(10, 8'h6A);
        run_frame(10, 1'b1, 1'b0, 1'b1, build_desc(1'b0, 1'b1, 1'b0));
        idle(3);
        check("idle_state", word_t'(state), word_t'(2'd0));

        // PTP class 4: timestamp 19'h5A5A5 into bytes 3..5; descriptor keeps original bytes.
        rec_ts = 19'h5A5A5;
        make_frame(8, 8'h81);
        fin[3] = 9'h0F8; fout[3] = 9'h0FD; fout[4] = 9'h0A5; fout[5] = 9'h0A5;
        run_frame(8, 1'b1, 1'b0, 1'b1, build_desc(1'b0, 1'b1, 1'b0));
        idle(2);

        // Standard frame at cnt == map_thr is dropped; cnt = map_thr+1 admitted, rc/be ignored.
        std_flag = 1'b1; free_cnt = 9'd16; map_thr = 9'd16; rc_thr = 9'd100; be_thr = 9'd100;
        make_frame(6, 8'h11);
        run_frame(6, 1'b0, 1'b0, 1'b0, '0);
        idle(3);
        check_counters("after_std_drop");
        free_cnt = 9'd17;
        make_frame(7, 8'h22);
        run_frame(7, 1'b1, 1'b0, 1'b1, build_desc(1'b1, 1'b1, 1'b1));
        idle(2);

        // Mapped class 6 below be threshold dropped; class 0 admitted at cnt=1, dropped at cnt=0.
        std_flag = 1'b0; free_cnt = 9'd30; be_thr = 9'd40; rc_thr = 9'd10; map_thr = 9'd0;
        make_frame(5, 8'hC3);
        run_frame(5, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        free_cnt = 9'd1; be_thr = 9'd40; rc_thr = 9'd40; map_thr = 9'd40;
        make_frame(7, 8'h05);
        run_frame(7, 1'b1, 1'b0, 1'b1, build_desc(1'b0, 1'b1, 1'b0));
        idle(1);
        free_cnt = 9'd0;
        make_frame(5, 8'h07);
        run_frame(5, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        // Unmapped non-standard port: lookup disabled, unmapped tag set.
        port_type = 1'b1; free_cnt = 9'd50; map_thr = 9'd20;
        make_frame(6, 8'h44);
        run_frame(6, 1'b1, 1'b0, 1'b1, build_desc(1'b0, 1'b0, 1'b1));
        idle(2);
        // Mapped class 3 exactly at rc threshold is dropped.
        port_type = 1'b0; free_cnt = 9'd20; rc_thr = 9'd20;
        make_frame(4, 8'h60);
        run_frame(4, 1'b0, 1'b0, 1'b0, '0);
        idle(3);
        check_counters("after_class_drops");

        // Truncated 4-byte frame, then a back-to-back normal frame.
        free_cnt = 9'd100; be_thr = '0; rc_thr = '0; map_thr = '0;
        make_frame(4, 8'h12);
        run_frame(4, 1'b1, 1'b1, 1'b0, '0);
        make_frame(8, 8'h34);
        run_frame(8, 1'b1, 1'b0, 1'b1, build_desc(1'b0, 1'b1, 1'b0));
        idle(3);
        check_counters("after_truncated");

        // Valid gap inside the header is an error.
        make_frame(8, 8'h56);
        for (int i = 0; i < 3; i++) begin
            drive_byte(fin[i], 1'b1);
            byte_q.push_back('{cyc + 1, fout[i]});
        end
        check("hdr_state", word_t'(state), word_t'(2'd1));
        drive_byte(9'h000, 1'b0);
        err_q.push_back(cyc + 1); exp_err++;
        idle(3);
        check_counters("after_gap");

        // Reset during byte 2; remainder ignored; next head processed normally.
        make_frame(10, 8'h78);
        for (int i = 0; i < 3; i++) begin
            drive_byte(fin[i], 1'b1);
            if (i < 2) byte_q.push_back('{cyc + 1, fout[i]});
        end
        #2 reset_n = 1'b0;
        byte_q.delete(); desc_q.delete(); disc_q.delete(); err_q.delete();
        exp_disc = 0; exp_err = 0;
        #1 check_all_zero("mid_reset");
        @(negedge clk_sys); reset_n = 1'b1;
        for (int i = 3; i < 8; i++) drive_byte(fin[i], 1'b1);
        make_frame(6, 8'hBA);
        run_frame(6, 1'b1, 1'b0, 1'b1, build_desc(1'b0, 1'b1, 1'b0));
        idle(4);
        check_counters("after_reset");
        check("byte_q_drained", word_t'(byte_q.size()), '0);
        check("desc_q_drained", word_t'(desc_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
